// File: rtl/jive_pkg.sv
// Shared definitions for the JiVe fetch stage: NOP encoding, reset PC,
// fetch FSM states and the prefetch FIFO entry layout.
package jive_pkg;

  localparam logic [31:0] JIVE_NOP      = 32'h0000_0013;
  localparam logic [31:0] JIVE_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DROP  = 2'd1,
    ST_MISAL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/jive_fetch_if.sv
// Instruction bus between the fetch stage (master) and memory (slave):
// single outstanding word read, request held until a one-cycle ack.
interface jive_fetch_if;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;

  modport master (output ibus_req, output ibus_addr, input ibus_ack, input ibus_rdata);
  modport slave  (input ibus_req, input ibus_addr, output ibus_ack, output ibus_rdata);
endinterface

// File: rtl/jive_fetch_fifo.sv
// Prefetch FIFO of {pc, inst} pairs with first-word fall-through read port.
// Flush wins over push; simultaneous push and pop keep occupancy unchanged.
module jive_fetch_fifo
  import jive_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jive_fetch.sv
// JiVe instruction fetch: credit-limited word reads into a prefetch FIFO and
// a registered instruction/PC handed to decode on every advance.
module jive_fetch
  import jive_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = JIVE_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_ena,
  input  logic               redirect_vld,
  input  logic [31:0]        redirect_pc,
  jive_fetch_if.master       ibus,
  output logic [31:0]        inst_reg_f,
  output logic [31:0]        pc_f,
  output logic               inst_vld_f,
  output logic               misalign_f
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_n;
  logic [31:0]   fetch_pc_q, fetch_pc_n;
  logic          req_q, req_n;
  logic [31:0]   addr_q, addr_n;
  logic          misal_pend_q, misal_pend_n;
  logic [31:0]   inst_n, pc_n;
  logic          vld_n, misal_n;

  logic          fifo_push, fifo_pop, fifo_flush;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, occ_n;
  fetch_entry_t  fifo_din, fifo_dout;
  logic          ack_take;

  assign ibus.ibus_req  = req_q;
  assign ibus.ibus_addr = addr_q;
  assign fifo_din       = '{pc: fetch_pc_q, inst: ibus.ibus_rdata};

  jive_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_n      = state_q;
    fetch_pc_n   = fetch_pc_q;
    req_n        = req_q;
    addr_n       = addr_q;
    misal_pend_n = misal_pend_q;
    inst_n       = inst_reg_f;
    pc_n         = pc_f;
    vld_n        = inst_vld_f;
    misal_n      = misalign_f;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    occ_n        = fifo_count;
    ack_take     = req_q && ibus.ibus_ack;

    if (redirect_vld) begin
      // Redirect beats any same-cycle ack or advance; an unacked read must drain first.
      fifo_flush   = 1'b1;
      fetch_pc_n   = redirect_pc;
      inst_n       = JIVE_NOP;
      vld_n        = 1'b0;
      misal_n      = 1'b0;
      misal_pend_n = 1'b0;
      if (req_q && !ibus.ibus_ack) begin
        state_n = ST_DROP;
      end else if (redirect_pc[1:0] != 2'b00) begin
        state_n      = ST_MISAL;
        req_n        = 1'b0;
        misal_pend_n = 1'b1;
      end else begin
        state_n = ST_RUN;
        req_n   = 1'b1;
        addr_n  = redirect_pc;
      end
    end else begin
      if (if_ena) begin
        if (state_q == ST_MISAL) begin
          inst_n       = JIVE_NOP;
          vld_n        = misal_pend_q;
          misal_n      = misal_pend_q;
          pc_n         = misal_pend_q ? fetch_pc_q : pc_f;
          misal_pend_n = 1'b0;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          inst_n   = fifo_dout.inst;
          pc_n     = fifo_dout.pc;
          vld_n    = 1'b1;
          misal_n  = 1'b0;
        end else begin
          inst_n  = JIVE_NOP;
          vld_n   = 1'b0;
          misal_n = 1'b0;
        end
      end

      case (state_q)
        ST_RUN: begin
          if (ack_take) begin
            fifo_push  = !fifo_full || fifo_pop;
            fetch_pc_n = fetch_pc_q + 32'd4;
          end
          occ_n = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
          if (!req_q || ack_take) begin
            req_n  = (occ_n < CW'(FIFO_DEPTH));
            addr_n = fetch_pc_n;
          end
        end
        ST_DROP: begin
          if (ack_take) begin
            if (fetch_pc_q[1:0] != 2'b00) begin
              state_n      = ST_MISAL;
              req_n        = 1'b0;
              misal_pend_n = 1'b1;
            end else begin
              state_n = ST_RUN;
              req_n   = 1'b1;
              addr_n  = fetch_pc_q;
            end
          end
        end
        default: req_n = 1'b0;
      endcase
    end
  end

  // Fetch/decode boundary register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      fetch_pc_q   <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      misal_pend_q <= 1'b0;
      inst_reg_f   <= JIVE_NOP;
      pc_f         <= RESET_PC;
      inst_vld_f   <= 1'b0;
      misalign_f   <= 1'b0;
    end else begin
      state_q      <= state_n;
      fetch_pc_q   <= fetch_pc_n;
      req_q        <= req_n;
      addr_q       <= addr_n;
      misal_pend_q <= misal_pend_n;
      inst_reg_f   <= inst_n;
      pc_f         <= pc_n;
      inst_vld_f   <= vld_n;
      misalign_f   <= misal_n;
    end
  end

endmodule

// File: tb/tb_jive_fetch.sv
// Bench for jive_fetch: startup vector table, scoreboard of the fetched
// stream, and directed redirect / stall / misalign / reset sequences.
module tb_jive_fetch;
  import jive_pkg::*;

  localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_ena;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic [31:0] inst_reg_f, pc_f;
  logic        inst_vld_f, misalign_f;
  logic [31:0] inst2, pc2;
  logic        vld2, mis2;
  logic [3:0]  wait_n;
  logic [3:0]  wcnt;

  always #5 clk = ~clk;

  jive_fetch_if bus ();
  jive_fetch_if bus2 ();

  jive_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_ena       (if_ena),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .ibus         (bus),
    .inst_reg_f   (inst_reg_f),
    .pc_f         (pc_f),
    .inst_vld_f   (inst_vld_f),
    .misalign_f   (misalign_f)
  );

  jive_fetch #(.RESET_PC(RPC2), .FIFO_DEPTH(2)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .if_ena       (1'b1),
    .redirect_vld (1'b0),
    .redirect_pc  (32'h0),
    .ibus         (bus2),
    .inst_reg_f   (inst2),
    .pc_f         (pc2),
    .inst_vld_f   (vld2),
    .misalign_f   (mis2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_0F00;
  endfunction

  // Memory models: programmable wait states for dut, zero-wait for dut2
  always_comb begin
    bus.ibus_ack   = bus.ibus_req && (wcnt == wait_n);
    bus.ibus_rdata = mem_word(bus.ibus_addr);
    bus2.ibus_ack   = bus2.ibus_req;
    bus2.ibus_rdata = mem_word(bus2.ibus_addr);
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.ibus_req || bus.ibus_ack) wcnt <= '0;
    else                                       wcnt <= wcnt + 4'd1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: accepted reads in address order, consumed on each valid advance
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] exp_pc   = 32'h0;
  logic        adv_prev = 1'b0;
  int          ack_cnt  = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (adv_prev && inst_vld_f && !misalign_f) begin
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
        end else begin
          e.pc   = 32'hDEAD_BEEF;
          e.inst = 32'hDEAD_BEEF;
        end
        check("sb_pc", pc_f, e.pc);
        check("sb_inst", inst_reg_f, e.inst);
      end
      if (bus.ibus_req && bus.ibus_ack) ack_cnt++;
      if (rst) begin
        sb_q.delete();
        exp_pc = 32'h0;
      end else if (redirect_vld) begin
        sb_q.delete();
        exp_pc = redirect_pc;
      end else if (bus.ibus_req && bus.ibus_ack && bus.ibus_addr == exp_pc) begin
        e.pc   = exp_pc;
        e.inst = mem_word(exp_pc);
        sb_q.push_back(e);
        exp_pc = exp_pc + 32'd4;
      end
      adv_prev = if_ena && !redirect_vld && !rst;
    end
  end

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] pc2;
  } vec_t;

  vec_t vec [6];

  initial begin
    int   s;
    logic found;
    vec[0] = '{1'b0, 32'h0,  1'b0, 32'h0, JIVE_NOP,         1'b0, RPC2,          RPC2};
    vec[1] = '{1'b1, 32'h0,  1'b0, 32'h0, JIVE_NOP,         1'b1, RPC2,          RPC2};
    vec[2] = '{1'b1, 32'h4,  1'b0, 32'h0, JIVE_NOP,         1'b1, 32'hFFFF_FFFC, RPC2};
    vec[3] = '{1'b1, 32'h8,  1'b1, 32'h0, mem_word(32'h0),  1'b1, 32'h0,         RPC2};
    vec[4] = '{1'b1, 32'hC,  1'b1, 32'h4, mem_word(32'h4),  1'b1, 32'h4,         32'hFFFF_FFFC};
    vec[5] = '{1'b1, 32'h10, 1'b1, 32'h8, mem_word(32'h8),  1'b1, 32'h8,         32'h0};

    if_ena = 1'b0; redirect_vld = 1'b0; redirect_pc = 32'h0; wait_n = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    if_ena = 1'b1;

    // Reset release and zero-wait streaming, both parameterisations
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("t1_req_c%0d", c),   32'(bus.ibus_req),  32'(vec[c].req));
      check($sformatf("t1_addr_c%0d", c),  bus.ibus_addr,      vec[c].addr);
      check($sformatf("t1_vld_c%0d", c),   32'(inst_vld_f),    32'(vec[c].vld));
      check($sformatf("t1_pc_c%0d", c),    pc_f,               vec[c].pc);
      check($sformatf("t1_inst_c%0d", c),  inst_reg_f,         vec[c].inst);
      check($sformatf("t1_mis_c%0d", c),   32'(misalign_f),    32'h0);
      check($sformatf("t1_req2_c%0d", c),  32'(bus2.ibus_req), 32'(vec[c].req2));
      check($sformatf("t1_addr2_c%0d", c), bus2.ibus_addr,     vec[c].addr2);
      check($sformatf("t1_pc2_c%0d", c),   pc2,                vec[c].pc2);
      @(posedge clk);
      #1;
    end
    cycles(8);

    // Stall from an empty FIFO: exactly FIFO_DEPTH reads accepted, then idle
    redirect_vld = 1'b1; redirect_pc = 32'h200; if_ena = 1'b0;
    cycles(1);
    redirect_vld = 1'b0;
    s = ack_cnt;
    cycles(2);
    @(negedge clk);
    check("t2_req_low_n3", 32'(bus.ibus_req), 32'h0);
    cycles(3);
    @(negedge clk);
    check("t2_req_low_n6", 32'(bus.ibus_req), 32'h0);
    cycles(1);
    check("t2_acks", 32'(ack_cnt - s), 32'd2);
    if_ena = 1'b1;
    cycles(10);

    // Redirect while a 3-wait read of 0x8 is outstanding
    if_ena = 1'b0;
    cycles(4);
    wait_n = 4'd3; redirect_vld = 1'b1; redirect_pc = 32'h8;
    cycles(1);
    redirect_pc = 32'h100;
    @(negedge clk);
    check("t3_req_m1", 32'(bus.ibus_req), 32'h1);
    check("t3_addr_m1", bus.ibus_addr, 32'h8);
    cycles(1);
    redirect_vld = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("t3_req_m%0d", k), 32'(bus.ibus_req), 32'h1);
      check($sformatf("t3_addr_m%0d", k), bus.ibus_addr, 32'h8);
      cycles(1);
    end
    wait_n = 4'd0; if_ena = 1'b1;
    @(negedge clk);
    check("t3_req_new", 32'(bus.ibus_req), 32'h1);
    check("t3_addr_new", bus.ibus_addr, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycles(1);
      @(negedge clk);
      if (inst_vld_f) found = 1'b1;
    end
    if (found) check("t3_first_pc", pc_f, 32'h100);
    else       check("t3_vld_timeout", 32'(inst_vld_f), 32'h1);
    cycles(6);

    // Misaligned redirect
    redirect_vld = 1'b1; redirect_pc = 32'h102;
    cycles(1);
    redirect_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("t4_req_p%0d", k), 32'(bus.ibus_req), 32'h0);
      check($sformatf("t4_inst_p%0d", k), inst_reg_f, JIVE_NOP);
      check($sformatf("t4_vld_p%0d", k), 32'(inst_vld_f), (k == 2) ? 32'h1 : 32'h0);
      check($sformatf("t4_mis_p%0d", k), 32'(misalign_f), (k == 2) ? 32'h1 : 32'h0);
      if (k == 2) check("t4_pc", pc_f, 32'h102);
      cycles(1);
    end

    // Redirect, ack and advance in the same cycle
    redirect_vld = 1'b1; redirect_pc = 32'h300;
    cycles(1);
    redirect_vld = 1'b0;
    cycles(6);
    redirect_vld = 1'b1; redirect_pc = 32'h400;
    @(negedge clk);
    check("t5_req_ack_same", {30'h0, bus.ibus_req, bus.ibus_ack}, 32'h3);
    cycles(1);
    redirect_vld = 1'b0;
    @(negedge clk);
    check("t5_addr_r1", bus.ibus_addr, 32'h400);
    check("t5_inst_r1", inst_reg_f, JIVE_NOP);
    check("t5_vld_r1", 32'(inst_vld_f), 32'h0);
    cycles(1);
    @(negedge clk);
    check("t5_vld_r2", 32'(inst_vld_f), 32'h0);
    cycles(1);
    @(negedge clk);
    check("t5_vld_r3", 32'(inst_vld_f), 32'h1);
    check("t5_pc_r3", pc_f, 32'h400);
    check("t5_inst_r3", inst_reg_f, mem_word(32'h400));
    cycles(3);

    // Reset in the middle of a burst
    @(negedge clk);
    check("t6_req2_busy", 32'(bus2.ibus_req), 32'h1);
    cycles(1);
    rst = 1'b1;
    cycles(1);
    @(negedge clk);
    check("t6_req", 32'(bus.ibus_req), 32'h0);
    check("t6_addr", bus.ibus_addr, 32'h0);
    check("t6_inst", inst_reg_f, JIVE_NOP);
    check("t6_pc", pc_f, 32'h0);
    check("t6_vld", 32'(inst_vld_f), 32'h0);
    check("t6_mis", 32'(misalign_f), 32'h0);
    check("t6_req2", 32'(bus2.ibus_req), 32'h0);
    check("t6_addr2", bus2.ibus_addr, RPC2);
    check("t6_pc2", pc2, RPC2);
    check("t6_inst2", inst2, JIVE_NOP);
    check("t6_vld2", 32'(vld2), 32'h0);
    check("t6_mis2", 32'(mis2), 32'h0);
    cycles(1);
    rst = 1'b0;
    cycles(1);
    @(negedge clk);
    check("t6_rel_req2", 32'(bus2.ibus_req), 32'h1);
    check("t6_rel_addr2", bus2.ibus_addr, RPC2);
    check("t6_rel_addr", bus.ibus_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule
